// File: rtl/data_memory_pipe.sv
// rtl/data_memory_pipe.sv - MIPS MEM-stage data memory with pipelined synchronous read
//
// Byte-addressed DEPTH x 32-bit data memory. Stores (sb/sh/sw) write byte lanes on the
// accept edge. Loads (lb/lbu/lh/lhu/lw) return RD_LAT cycles after accept, in order.
// Misaligned and out-of-range accesses are flagged with pulses that travel with the request.
//
// Optional feature macro: DMEM_CLEAR_EN
//   defined   : after reset release the array is swept to zero, one word per cycle,
//               with ready low until the sweep completes.
//   undefined : ready is high from reset release and the array content is undefined.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   MemRead    in   load request
//   MemWrite   in   store request (wins when both are set; no readValid)
//   size       in   00 byte, 01 half, 10 word, 11 reserved (flagged misaligned)
//   signExt    in   loads: 1 sign-extend, 0 zero-extend
//   address    in   byte address
//   writeData  in   right-justified store data
//   ready      out  request accepted this cycle when high
//   readData   out  extended load result, held between readValid pulses
//   readValid  out  one-cycle pulse, readData valid
//   misaligned out  one-cycle pulse, misaligned or reserved size
//   rangeErr   out  one-cycle pulse, address >= DEPTH*4

module data_memory_pipe #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        size,
  input  logic              signExt,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writeData,
  output logic              ready,
  output logic [31:0]       readData,
  output logic              readValid,
  output logic              misaligned,
  output logic              rangeErr
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  // Per-request control carried down the read pipeline.
  typedef struct packed {
    logic       ld;   // accepted load (not a combined read+write)
    logic       mis;
    logic       rng;
    logic [1:0] off;
    logic [1:0] sz;
    logic       sx;
  } ctl_t;

  state_t           state_q, state_d;
  logic [31:0]      mem [DEPTH];

  logic             accept;
  logic             rng_err;
  logic             mis_err;
  logic [IDX_W-1:0] idx;
  ctl_t             req_ctl;

  logic             we;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_data;
  logic [3:0]       w_be;

  ctl_t             fin_ctl;
  logic [31:0]      fin_raw;

  logic             read_valid_q;
  logic             misaligned_q;
  logic             range_err_q;
  logic [31:0]      read_data_q;

  assign ready = (state_q == S_IDLE);

  // Request decode. Range is checked first; an out-of-range access never reports misaligned.
  always_comb begin
    accept  = ready & (MemRead | MemWrite);
    rng_err = (address >> (IDX_W + 2)) != '0;
    case (size)
      2'b00:   mis_err = 1'b0;
      2'b01:   mis_err = address[0];
      2'b10:   mis_err = |address[1:0];
      default: mis_err = 1'b1;
    endcase
    mis_err = mis_err & ~rng_err;
    idx     = address[IDX_W+1:2];

    req_ctl     = '0;
    req_ctl.ld  = accept & MemRead & ~MemWrite;
    req_ctl.mis = accept & mis_err;
    req_ctl.rng = accept & rng_err;
    req_ctl.off = address[1:0];
    req_ctl.sz  = size;
    req_ctl.sx  = signExt;
  end

`ifdef DMEM_CLEAR_EN
  logic [IDX_W-1:0] clr_q, clr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr_q <= '0;
    else        clr_q <= clr_d;
  end
`endif

  // FSM next state and the single array write port (store or clear sweep).
  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    w_idx   = idx;
    case (size)
      2'b00: begin
        w_data = {4{writeData[7:0]}};
        w_be   = 4'b0001 << address[1:0];
      end
      2'b01: begin
        w_data = {2{writeData[15:0]}};
        w_be   = address[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_data = writeData;
        w_be   = 4'b1111;
      end
    endcase
`ifdef DMEM_CLEAR_EN
    clr_d = clr_q;
`endif
    case (state_q)
      S_IDLE: begin
        we = accept & MemWrite & ~rng_err & ~mis_err;
      end
`ifdef DMEM_CLEAR_EN
      S_CLEAR: begin
        we     = 1'b1;
        w_idx  = clr_q;
        w_data = '0;
        w_be   = 4'b1111;
        clr_d  = clr_q + 1'b1;
        if (clr_q == IDX_W'(DEPTH - 1)) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef DMEM_CLEAR_EN
      state_q <= S_CLEAR;
`else
      state_q <= S_IDLE;
`endif
    end else begin
      state_q <= state_d;
    end
  end

  // Array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  // Read path: the array is sampled on the accept edge. With RD_LAT=1 that sample is the
  // output register itself, so the word feeds lane select combinationally.
  if (RD_LAT == 1) begin : g_lat1
    always_comb begin
      fin_ctl = req_ctl;
      fin_raw = mem[idx];
    end
  end else begin : g_latn
    ctl_t        ctl_q [RD_LAT-1];
    logic [31:0] raw_q [RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < RD_LAT - 1; i++) begin
          ctl_q[i] <= '0;
          raw_q[i] <= '0;
        end
      end else begin
        ctl_q[0] <= req_ctl;
        raw_q[0] <= mem[idx];
        for (int i = 1; i < RD_LAT - 1; i++) begin
          ctl_q[i] <= ctl_q[i-1];
          raw_q[i] <= raw_q[i-1];
        end
      end
    end

    assign fin_ctl = ctl_q[RD_LAT-2];
    assign fin_raw = raw_q[RD_LAT-2];
  end

  function automatic logic [31:0] extend(input logic [31:0] w, input ctl_t c);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {c.off, 3'b000});
    h = c.off[1] ? w[31:16] : w[15:0];
    if (c.mis | c.rng) return '0;
    case (c.sz)
      2'b00:   return c.sx ? {{24{b[7]}}, b}  : {24'b0, b};
      2'b01:   return c.sx ? {{16{h[15]}}, h} : {16'b0, h};
      default: return w;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      range_err_q  <= 1'b0;
      read_data_q  <= '0;
    end else begin
      read_valid_q <= fin_ctl.ld;
      misaligned_q <= fin_ctl.mis;
      range_err_q  <= fin_ctl.rng;
      if (fin_ctl.ld) read_data_q <= extend(fin_raw, fin_ctl);
    end
  end

  assign readData   = read_data_q;
  assign readValid  = read_valid_q;
  assign misaligned = misaligned_q;
  assign rangeErr   = range_err_q;

endmodule
